// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding, the default width and the counter-width helper.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   localparam int WIDTH_DEFAULT = 8;

   // Counter must be able to hold WIDTH itself, hence the +1.
   function automatic int cntWidth(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_adder_piso_shift_reg.sv
// Parallel-load, right-shift operand register feeding one bit per cycle to the adder.
// Load has priority over shift; the LSB is presented on lsb_o.
module piso_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             lsb_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = data_i;
      end else if (shift_i) begin
         data_d = {1'b0, data_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign lsb_o = data_q[0];

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add step per clock, LSB first, WIDTH cycles per add.
// Optional two's-complement overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             c_out
);

   localparam int CNT_W = cntWidth(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic aBit, bBit;
   logic loadOps, shiftOps;
   logic sBit, carryNext;

   assign loadOps  = (state_q == IDLE) && start;
   assign shiftOps = (state_q == SHIFT);

   piso_shift_reg #(.WIDTH(WIDTH)) u_aReg (
      .clk    (clk),
      .rst    (rst),
      .load_i (loadOps),
      .shift_i(shiftOps),
      .data_i (a),
      .lsb_o  (aBit)
   );

   piso_shift_reg #(.WIDTH(WIDTH)) u_bReg (
      .clk    (clk),
      .rst    (rst),
      .load_i (loadOps),
      .shift_i(shiftOps),
      .data_i (b),
      .lsb_o  (bBit)
   );

   assign sBit      = aBit ^ bBit ^ carry_q;
   assign carryNext = (aBit & bBit) | (aBit & carry_q) | (bBit & carry_q);

   // Sum bits enter from the MSB side so after WIDTH steps bit 0 lands in sum[0].
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               carry_d = c_in;
               sum_d   = '0;
               cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         SHIFT: begin
            sum_d   = {sBit, sum_q[WIDTH-1:1]};
            carry_d = carryNext;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               cout_d  = carryNext;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q here is the carry into the MSB.
               ovf_d   = carry_q ^ carryNext;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy  = (state_q == SHIFT) || (state_q == DONE);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign c_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed table, random vectors against an
// arithmetic reference, plus ignored-start and mid-operation reset sequences.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         c_in;
   logic         busy, done, c_out;
   logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[6];

   serial_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .c_in (c_in),
      .busy (busy),
      .done (done),
      .sum  (sum),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf  (ovf),
`endif
      .c_out(c_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain unsigned addition; overflow when like-signed operands give an unlike-signed result.
   function automatic logic [W+1:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W:0] full;
      logic       ov;
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
      return {ov, full};
   endfunction

   task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after done falls.
   task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                                input logic [W-1:0] eSum, input logic eCout, input logic eOvf);
      int busyCnt;
      int doneAt;
      busyCnt = 0;
      doneAt  = -1;
      a = ta; b = tb; c_in = tc; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (busy) busyCnt++;
         if (done) begin
            doneAt = k;
            break;
         end
      end
      if (doneAt < 0) begin
         checkOutput("done_timeout", 0, 1);
      end else begin
         checkOutput("latency", 32'(doneAt - 1), 32'(W));
         checkOutput("busy_cycles", 32'(busyCnt), 32'(W + 1));
         checkOutput("sum", 32'(sum), 32'(eSum));
         checkOutput("c_out", 32'(c_out), 32'(eCout));
`ifdef SERIAL_ADDER_OVF_EN
         checkOutput("ovf", 32'(ovf), 32'(eOvf));
`else
         if (eOvf === 1'bx) checkOutput("ovf_ref", 0, 1);
`endif
         @(negedge clk);
         checkOutput("done_pulse_width", 32'(done), 0);
         checkOutput("busy_after_done", 32'(busy), 0);
         checkOutput("sum_held", 32'(sum), 32'(eSum));
      end
   endtask

   initial begin
      logic [W+1:0] r;
      logic [W-1:0] ra, rb;
      logic         rc;
      int           doneCnt;
      logic [W-1:0] sumAtDone;

      vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

      rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; c_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_done", 32'(done), 0);
      checkOutput("reset_sum", 32'(sum), 0);
      checkOutput("reset_c_out", 32'(c_out), 0);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("reset_ovf", 32'(ovf), 0);
`endif
      rst = 1'b0; start = 1'b0;
      @(negedge clk);

      $display("[TB] directed table");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      end

      $display("[TB] random vectors");
      for (int i = 0; i < 25; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         r  = refAdd(ra, rb, rc);
         applyStimulus(ra, rb, rc, r[W-1:0], r[W], r[W+1]);
      end

      $display("[TB] start while busy");
      a = 8'h35; b = 8'h4A; c_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'h11; b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      doneCnt = 0;
      sumAtDone = '0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done) begin
            doneCnt++;
            sumAtDone = sum;
         end
      end
      checkOutput("ignored_start_done_count", 32'(doneCnt), 1);
      checkOutput("ignored_start_sum", 32'(sumAtDone), 32'h7F);

      $display("[TB] reset mid-operation");
      a = 8'hFF; b = 8'h01; c_in = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_done", 32'(done), 0);
      checkOutput("abort_sum", 32'(sum), 0);
      checkOutput("abort_c_out", 32'(c_out), 0);
      doneCnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) doneCnt++;
      end
      checkOutput("abort_no_done", 32'(doneCnt), 0);

      applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
